// File: rtl/lsu.sv
// lsu: EX/MEM load/store unit; one req/ack data-bus transaction per memory instruction.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module lsu #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mtype_i,
  input  logic              ex_mem_rw_i,
  input  logic [1:0]        ex_mem_width_i,
  input  logic              ex_mem_rdtype_i,
  input  logic [AW-1:0]     ex_addr_i,
  input  logic [DW-1:0]     ex_wdata_i,
  output logic              lsu_stall_o,
  output logic [DW-1:0]     lsu_rdata_o,
  output logic              lsu_rdata_valid_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [AW-1:0]     dbus_addr_o,
  output logic [DW/8-1:0]   dbus_be_o,
  output logic [DW-1:0]     dbus_wdata_o,
  input  logic              dbus_ack_i,
  input  logic [DW-1:0]     dbus_rdata_i
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              lsu_misalign_o,
  output logic [AW-1:0]     lsu_bad_addr_o
`endif
);

  localparam int unsigned BW = DW / 8;

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_BYTE = 2'd1;
  localparam logic [1:0] W_HALF = 2'd2;
  localparam logic [1:0] W_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          accept;
  logic          trap_c;
  logic          mis_q;
  logic          rw_q;
  logic          rdtype_q;
  logic [1:0]    width_q;
  logic [1:0]    lane_q;
  logic [BW-1:0] be_c;
  logic [DW-1:0] wdata_c;
  logic [4:0]    shamt;
  logic [DW-1:0] shifted;
  logic [DW-1:0] load_c;

  // Byte enables and lane-replicated store data for the incoming instruction
  always_comb begin
    be_c    = '0;
    wdata_c = ex_wdata_i;
    case (ex_mem_width_i)
      W_BYTE: begin
        be_c    = BW'(4'b0001 << ex_addr_i[1:0]);
        wdata_c = {(DW/8){ex_wdata_i[7:0]}};
      end
      W_HALF: begin
        be_c    = BW'(4'b0011 << {ex_addr_i[1], 1'b0});
        wdata_c = {(DW/16){ex_wdata_i[15:0]}};
      end
      W_WORD: be_c = '1;
      default: ;
    endcase
  end

  // Lane extraction and sign/zero extension of the returned bus word
  always_comb begin
    shamt = '0;
    case (width_q)
      W_BYTE:  shamt = {lane_q, 3'b000};
      W_HALF:  shamt = {lane_q[1], 4'b0000};
      default: ;
    endcase
    shifted = dbus_rdata_i >> shamt;
    load_c  = shifted;
    case (width_q)
      W_BYTE:  load_c = {{(DW-8){~rdtype_q & shifted[7]}}, shifted[7:0]};
      W_HALF:  load_c = {{(DW-16){~rdtype_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt         = state;
    accept            = 1'b0;
    lsu_stall_o       = 1'b0;
    dbus_req_o        = 1'b0;
    lsu_rdata_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (ex_mtype_i && (ex_mem_width_i != W_NONE)) begin
          accept      = 1'b1;
          lsu_stall_o = 1'b1;
          state_nxt   = trap_c ? DONE : REQ;
        end
      end
      REQ: begin
        dbus_req_o  = 1'b1;
        lsu_stall_o = 1'b1;
        if (dbus_ack_i) state_nxt = DONE;
      end
      DONE: begin
        // inputs still hold the finished instruction, so never accept here
        lsu_rdata_valid_o = rw_q & ~mis_q;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, captured request and load result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rw_q         <= 1'b0;
      rdtype_q     <= 1'b0;
      width_q      <= W_NONE;
      lane_q       <= 2'b00;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      lsu_rdata_o  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rw_q         <= ex_mem_rw_i;
        rdtype_q     <= ex_mem_rdtype_i;
        width_q      <= ex_mem_width_i;
        lane_q       <= ex_addr_i[1:0];
        dbus_we_o    <= ~ex_mem_rw_i;
        dbus_addr_o  <= {ex_addr_i[AW-1:2], 2'b00};
        dbus_be_o    <= be_c;
        dbus_wdata_o <= wdata_c;
      end
      if ((state == REQ) && dbus_ack_i && rw_q) lsu_rdata_o <= load_c;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign trap_c = ((ex_mem_width_i == W_HALF) && ex_addr_i[0]) ||
                  ((ex_mem_width_i == W_WORD) && (ex_addr_i[1:0] != 2'b00));

  assign lsu_misalign_o = (state == DONE) & mis_q;

  // Trap flag for the current instruction and sticky faulting address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q          <= 1'b0;
      lsu_bad_addr_o <= '0;
    end else if (accept) begin
      mis_q <= trap_c;
      if (trap_c) lsu_bad_addr_o <= ex_addr_i;
    end
  end
`else
  assign trap_c = 1'b0;
  assign mis_q  = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed plus randomized checks of lsu against a lane-arithmetic reference model.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        mtype;
  logic        mem_rw;
  logic [1:0]  width;
  logic        rdtype;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        valid;
  logic        req;
  logic        we;
  logic [31:0] dbus_addr;
  logic [3:0]  be;
  logic [31:0] dbus_wdata;
  logic        ack;
  logic [31:0] dbus_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
  logic [31:0] bad_addr;
`endif

  int          n_assert;
  int          n_fail;
  logic [31:0] exp_last;

  lsu #(.AW(32), .DW(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mtype_i        (mtype),
    .ex_mem_rw_i       (mem_rw),
    .ex_mem_width_i    (width),
    .ex_mem_rdtype_i   (rdtype),
    .ex_addr_i         (addr),
    .ex_wdata_i        (wdata),
    .lsu_stall_o       (stall),
    .lsu_rdata_o       (rdata),
    .lsu_rdata_valid_o (valid),
    .dbus_req_o        (req),
    .dbus_we_o         (we),
    .dbus_addr_o       (dbus_addr),
    .dbus_be_o         (be),
    .dbus_wdata_o      (dbus_wdata),
    .dbus_ack_i        (ack),
    .dbus_rdata_i      (dbus_rdata)
`ifdef MISALIGN_TRAP_EN
    ,
    .lsu_misalign_o    (misalign),
    .lsu_bad_addr_o    (bad_addr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: which bytes of the aligned word an access touches
  function automatic logic [3:0] exp_be(input logic [1:0] w, input logic [31:0] a);
    case (w)
      2'd1:    return 4'(1 << (a % 4));
      2'd2:    return a[1] ? 4'b1100 : 4'b0011;
      2'd3:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] w, input logic [31:0] d);
    case (w)
      2'd1:    return 32'h0101_0101 * {24'd0, d[7:0]};
      2'd2:    return 32'h0001_0001 * {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] w, input logic rdt,
                                           input logic [31:0] a, input logic [31:0] d);
    int          lane;
    logic [31:0] v;
    lane = (w == 2'd1) ? int'(a % 4) : (w == 2'd2) ? int'(a & 32'd2) : 0;
    v = d >> (8 * lane);
    if (w == 2'd1) begin
      v = v & 32'h0000_00FF;
      if (!rdt && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd2) begin
      v = v & 32'h0000_FFFF;
      if (!rdt && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One complete memory instruction; starts and ends at a falling edge
  task automatic run_op(input logic rw, input logic [1:0] w, input logic rdt,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly);
    int stalls;
    chkb("idle_noreq", req, 1'b0);
    mtype = 1'b1; mem_rw = rw; width = w; rdtype = rdt; addr = a; wdata = wd;
    #1;
    chkb("accept_stall", stall, 1'b1);
    stalls = int'(stall);
    @(negedge clk);
    for (int i = 0; i <= dly; i++) begin
      chkb("req", req, 1'b1);
      chk("addr", dbus_addr, a & 32'hFFFF_FFFC);
      chkb("we", we, ~rw);
      chk("be", 32'(be), 32'(exp_be(w, a)));
      if (!rw) chk("wdata", dbus_wdata, exp_wdata(w, wd));
      chkb("no_early_valid", valid, 1'b0);
      stalls += int'(stall);
      if (i == dly) begin
        ack = 1'b1;
        dbus_rdata = rd;
      end
      @(negedge clk);
      ack = 1'b0;
      dbus_rdata = $urandom;
    end
    if (rw) exp_last = exp_load(w, rdt, a, rd);
    chkb("done_noreq", req, 1'b0);
    chkb("done_stall", stall, 1'b0);
    chkb("valid", valid, rw);
    chk("rdata", rdata, exp_last);
    chk("stall_cycles", 32'(stalls), 32'(dly + 2));
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    mtype = 1'b0;
    @(negedge clk);
    chkb("idle_req", req, 1'b0);
    chkb("idle_valid", valid, 1'b0);
  endtask

  initial begin
    logic [1:0]  rw_w;
    logic [31:0] ra;
    n_assert = 0; n_fail = 0; exp_last = 32'd0;
    rst_n = 1'b0; mtype = 1'b0; mem_rw = 1'b0; width = 2'd0; rdtype = 1'b0;
    addr = 32'd0; wdata = 32'd0; ack = 1'b0; dbus_rdata = 32'd0;

    repeat (3) @(negedge clk);
    chkb("rst_req", req, 1'b0);
    chkb("rst_stall", stall, 1'b0);
    chkb("rst_valid", valid, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    chkb("rst_we", we, 1'b0);
    chk("rst_be", 32'(be), 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LB, ack in first REQ cycle
    run_op(1'b1, 2'd1, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 0);
    chk("lb_result", rdata, 32'hFFFF_FF80);
    // LHU, three wait cycles
    run_op(1'b1, 2'd2, 1'b1, 32'h0000_2002, 32'd0, 32'hBEEF_1234, 3);
    chk("lhu_result", rdata, 32'h0000_BEEF);
    // SB
    run_op(1'b0, 2'd1, 1'b0, 32'h0000_3001, 32'h1234_56AB, 32'h5555_5555, 0);
    // SW then LW back to back
    run_op(1'b0, 2'd3, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 1);
    run_op(1'b1, 2'd3, 1'b1, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_result", rdata, 32'hDEAD_BEEF);

    // width 0 is not an access
    mtype = 1'b1; mem_rw = 1'b1; width = 2'd0; addr = 32'h0000_6000;
    #1;
    chkb("w0_stall", stall, 1'b0);
    @(negedge clk);
    chkb("w0_req", req, 1'b0);
    chkb("w0_stall2", stall, 1'b0);
    idle_cycle();

`ifdef MISALIGN_TRAP_EN
    mtype = 1'b1; mem_rw = 1'b1; width = 2'd3; rdtype = 1'b0; addr = 32'h0000_5002;
    #1;
    chkb("trap_accept_stall", stall, 1'b1);
    @(negedge clk);
    chkb("trap_noreq", req, 1'b0);
    chkb("trap_pulse", misalign, 1'b1);
    chk("trap_addr", bad_addr, 32'h0000_5002);
    chkb("trap_novalid", valid, 1'b0);
    chkb("trap_stall", stall, 1'b0);
    @(negedge clk);
    chkb("trap_pulse_end", misalign, 1'b0);
    chk("trap_addr_hold", bad_addr, 32'h0000_5002);
    chkb("trap_noreq2", req, 1'b0);
    idle_cycle();
`else
    // misaligned word performed as an aligned word access
    run_op(1'b1, 2'd3, 1'b0, 32'h0000_5002, 32'd0, 32'hA5A5_0F0F, 1);
`endif

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      rw_w = 2'($urandom_range(1, 3));
      ra = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (rw_w == 2'd2) ra[0] = 1'b0;
      if (rw_w == 2'd3) ra[1:0] = 2'b00;
`endif
      run_op(1'($urandom_range(0, 1)), rw_w, 1'($urandom_range(0, 1)), ra,
             $urandom, $urandom, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // reset while waiting in REQ drops the transaction
    chkb("pre_rst_idle", req, 1'b0);
    mtype = 1'b1; mem_rw = 1'b1; width = 2'd3; addr = 32'h0000_7000;
    @(negedge clk);
    chkb("rst_mid_req", req, 1'b1);
    rst_n = 1'b0; mtype = 1'b0;
    @(negedge clk);
    exp_last = 32'd0;
    chkb("rst_mid_noreq", req, 1'b0);
    chkb("rst_mid_nostall", stall, 1'b0);
    chkb("rst_mid_novalid", valid, 1'b0);
    rst_n = 1'b1; ack = 1'b1; dbus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    ack = 1'b0;
    chkb("late_ack_noreq", req, 1'b0);
    chkb("late_ack_novalid", valid, 1'b0);
    chk("late_ack_rdata", rdata, exp_last);
    @(negedge clk);
    chkb("late_ack_novalid2", valid, 1'b0);

    // normal operation resumes after reset
    run_op(1'b1, 2'd1, 1'b1, 32'h0000_8002, 32'd0, 32'h00C3_0000, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
